// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply/divide sequencer.
// DIVZERO_FLAG_EN adds the div_by_zero result flag.
interface hilo_muldiv_if;
  logic        start;
  logic [3:0]  alu_control;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
  logic        rd_req;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef DIVZERO_FLAG_EN
  logic        div_by_zero;
`endif

  modport master (
    output start, alu_control, op1, op2, mthi, mtlo, mt_data, rd_req,
`ifdef DIVZERO_FLAG_EN
    input  div_by_zero,
`endif
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, alu_control, op1, op2, mthi, mtlo, mt_data, rd_req,
`ifdef DIVZERO_FLAG_EN
    output div_by_zero,
`endif
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: fixed-latency multiply, 32-step restoring divide, MTHI/MTLO and stall generation.
// Optional macro DIVZERO_FLAG_EN adds a div_by_zero pulse aligned with done.
module hilo_muldiv_ctrl #(
  parameter int unsigned MULT_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  hilo_muldiv_if.slave      bus
);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_ITER, DIV_FIX} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] op1_q, op1_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        mul_signed;
  logic        div_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    mul_signed = (bus.alu_control == OP_MULT);
    div_signed = (bus.alu_control == OP_DIV);
    mul_a      = {{32{mul_signed & bus.op1[31]}}, bus.op1};
    mul_b      = {{32{mul_signed & bus.op2[31]}}, bus.op2};
    product    = mul_a * mul_b;
    op1_abs    = (div_signed && bus.op1[31]) ? -bus.op1 : bus.op1;
    op2_abs    = (div_signed && bus.op2[31]) ? -bus.op2 : bus.op2;

    // Restoring step: borrow in bit 32 means the trial subtract is discarded.
    shifted    = {rem_q, quo_q[31]};
    trial      = shifted - {1'b0, dvsr_q};

    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    op1_d     = op1_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mthi) hi_d = bus.mt_data;
        if (bus.mtlo) lo_d = bus.mt_data;
        if (bus.start) begin
          case (bus.alu_control)
            OP_MULT, OP_MULTU: begin
              // Product is formed at issue and parked in rem/quo while the latency elapses.
              {rem_d, quo_d} = product;
              cnt_d          = 5'(MULT_LATENCY - 1);
              state_d        = MUL_WAIT;
              busy_d         = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              rem_d     = '0;
              quo_d     = op1_abs;
              dvsr_d    = op2_abs;
              op1_d     = bus.op1;
              neg_quo_d = div_signed && (bus.op1[31] ^ bus.op2[31]);
              neg_rem_d = div_signed && bus.op1[31];
              dz_d      = (bus.op2 == '0);
              cnt_d     = 5'd31;
              state_d   = DIV_ITER;
              busy_d    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      MUL_WAIT: begin
        if (cnt_q == '0) begin
          hi_d    = rem_q;
          lo_d    = quo_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DIV_ITER: begin
        rem_d = trial[32] ? shifted[31:0] : trial[31:0];
        quo_d = {quo_q[30:0], ~trial[32]};
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DIV_FIX: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = op1_q;
        end else begin
          lo_d = neg_quo_q ? -quo_q : quo_q;
          hi_d = neg_rem_q ? -rem_q : rem_q;
        end
        dbz_d   = dz_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      op1_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      op1_q     <= op1_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.stall = busy_q && (bus.start || bus.mthi || bus.mtlo || bus.rd_req);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

`ifdef DIVZERO_FLAG_EN
  assign bus.div_by_zero = dbz_q;
`else
  logic unused_dbz;
  assign unused_dbz = dbz_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomised and directed self-checking bench for hilo_muldiv_ctrl against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;
  localparam int unsigned MLAT = 4;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  hilo_muldiv_if bif ();

  hilo_muldiv_ctrl #(.MULT_LATENCY(MLAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output int cyc);
    logic [63:0] p;
    int sa, sb;
    h = '0; l = '0; cyc = 33;
    case (c)
      4'b0000: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        {h, l} = p; cyc = int'(MLAT);
      end
      4'b1001: begin
        p = {32'h0, a} * {32'h0, b};
        {h, l} = p; cyc = int'(MLAT);
      end
      4'b1101: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin h = 0; l = 32'h8000_0000; end
        else begin
          sa = $signed(a); sb = $signed(b);
          l = 32'(sa / sb); h = 32'(sa % sb);
        end
      end
      4'b1100: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
      default: cyc = 0;
    endcase
  endfunction

  // Issues one op and runs until busy drops; returns what was observed, no judging.
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output int cycles, output logic dn, output logic [31:0] h,
                       output logic [31:0] l, output logic dz);
    bif.start = 1'b1; bif.alu_control = c; bif.op1 = a; bif.op2 = b;
    step();
    bif.start = 1'b0;
    cycles = 0;
    while (bif.busy === 1'b1 && cycles < 200) begin
      cycles++;
      step();
    end
    dn = bif.done; h = bif.hi; l = bif.lo;
`ifdef DIVZERO_FLAG_EN
    dz = bif.div_by_zero;
`else
    dz = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bif.busy); end
    checks++; if (bif.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bif.done); end
    checks++; if (bif.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got %h want 0", bif.hi); end
    checks++; if (bif.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got %h want 0", bif.lo); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mult();
    int cyc; logic dn, dz; logic [31:0] h, l;
    do_op(4'b0000, 32'hFFFF_FFFE, 32'd3, cyc, dn, h, l, dz);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL mult_latency got %0d want 4", cyc); end
    checks++; if (dn !== 1'b1) begin failures++; $display("FAIL mult_done got %b want 1", dn); end
    checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFA) begin failures++; $display("FAIL mult_result got %h_%h want ffffffff_fffffffa", h, l); end
    do_op(4'b1001, 32'hFFFF_FFFE, 32'd3, cyc, dn, h, l, dz);
    checks++; if (cyc !== 4) begin failures++; $display("FAIL multu_latency got %0d want 4", cyc); end
    checks++; if ({h, l} !== 64'h0000_0002_FFFF_FFFA) begin failures++; $display("FAIL multu_result got %h_%h want 00000002_fffffffa", h, l); end
  endtask

  task automatic test_div();
    int cyc; logic dn, dz; logic [31:0] h, l;
    do_op(4'b1101, 32'hFFFF_FFF9, 32'd2, cyc, dn, h, l, dz);
    checks++; if (cyc !== 33) begin failures++; $display("FAIL div_latency got %0d want 33", cyc); end
    checks++; if (dn !== 1'b1) begin failures++; $display("FAIL div_done got %b want 1", dn); end
    checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", h, l); end
    do_op(4'b1100, 32'd100, 32'd7, cyc, dn, h, l, dz);
    checks++; if (cyc !== 33) begin failures++; $display("FAIL divu_latency got %0d want 33", cyc); end
    checks++; if ({h, l} !== {32'd2, 32'd14}) begin failures++; $display("FAIL divu_result got %h_%h want 2_14", h, l); end
    do_op(4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dn, h, l, dz);
    checks++; if ({h, l} !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL div_overflow got %h_%h want 0_80000000", h, l); end
    do_op(4'b1100, 32'd5, 32'd0, cyc, dn, h, l, dz);
    checks++; if ({h, l} !== 64'h0000_0005_FFFF_FFFF) begin failures++; $display("FAIL divu_zero got %h_%h want 5_ffffffff", h, l); end
    checks++; if (cyc !== 33) begin failures++; $display("FAIL divzero_latency got %0d want 33", cyc); end
`ifdef DIVZERO_FLAG_EN
    checks++; if (dz !== 1'b1) begin failures++; $display("FAIL divzero_flag got %b want 1", dz); end
`endif
    do_op(4'b1101, 32'hFFFF_FFF0, 32'd0, cyc, dn, h, l, dz);
    checks++; if ({h, l} !== 64'hFFFF_FFF0_FFFF_FFFF) begin failures++; $display("FAIL div_zero_signed got %h_%h want fffffff0_ffffffff", h, l); end
    do_op(4'b1101, 32'd9, 32'd4, cyc, dn, h, l, dz);
`ifdef DIVZERO_FLAG_EN
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL divzero_flag_clear got %b want 0", dz); end
`endif
  endtask

  task automatic test_random_back_to_back();
    logic [3:0] ops [4];
    logic [3:0] c; logic [31:0] a, b, eh, el, h, l;
    int ecyc, cyc; logic dn, dz;
    ops[0] = 4'b0000; ops[1] = 4'b1001; ops[2] = 4'b1101; ops[3] = 4'b1100;
    for (int i = 0; i < 40; i++) begin
      c = ops[$urandom_range(3, 0)];
      a = $urandom; b = $urandom;
      if ($urandom_range(7, 0) == 0) b = '0;
      if ($urandom_range(3, 0) == 0) b = b >> $urandom_range(31, 1);
      if ($urandom_range(15, 0) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      model(c, a, b, eh, el, ecyc);
      do_op(c, a, b, cyc, dn, h, l, dz);
      checks++; if (cyc !== ecyc) begin failures++; $display("FAIL rand_latency op=%b got %0d want %0d", c, cyc, ecyc); end
      checks++; if (dn !== 1'b1) begin failures++; $display("FAIL rand_done op=%b got %b want 1", c, dn); end
      checks++; if ({h, l} !== {eh, el}) begin failures++; $display("FAIL rand_result op=%b a=%h b=%h got %h_%h want %h_%h", c, a, b, h, l, eh, el); end
`ifdef DIVZERO_FLAG_EN
      checks++; if (dz !== (c[3:2] == 2'b11 && b == 0)) begin failures++; $display("FAIL rand_dz got %b", dz); end
`endif
    end
  endtask

  task automatic test_mt_idle();
    bif.mthi = 1'b1; bif.mtlo = 1'b1; bif.mt_data = 32'h5555_5555; bif.rd_req = 1'b1;
    #1;
    checks++; if (bif.stall !== 1'b0) begin failures++; $display("FAIL idle_stall got %b want 0", bif.stall); end
    step();
    bif.mthi = 1'b0; bif.mtlo = 1'b0; bif.rd_req = 1'b0;
    checks++; if ({bif.hi, bif.lo} !== 64'h5555_5555_5555_5555) begin failures++; $display("FAIL mt_both got %h_%h want 55555555_55555555", bif.hi, bif.lo); end
    bif.mtlo = 1'b1; bif.mt_data = 32'h0BAD_F00D;
    step();
    bif.mtlo = 1'b0;
    checks++; if ({bif.hi, bif.lo} !== 64'h5555_5555_0BAD_F00D) begin failures++; $display("FAIL mtlo_only got %h_%h want 55555555_0badf00d", bif.hi, bif.lo); end
  endtask

  task automatic test_stall();
    int n; int stall_bad = 0; int hi_bad = 0;
    bif.start = 1'b1; bif.alu_control = 4'b1101; bif.op1 = 32'hFFFF_FFF9; bif.op2 = 32'd2;
    step();
    bif.alu_control = 4'b1001; bif.op1 = 32'd7; bif.op2 = 32'd9;
    bif.rd_req = 1'b1; bif.mthi = 1'b1; bif.mt_data = 32'h1234;
    n = 0;
    while (bif.busy === 1'b1 && n < 200) begin
      if (bif.stall !== 1'b1) stall_bad++;
      if (bif.hi !== 32'h5555_5555) hi_bad++;
      n++;
      step();
    end
    checks++; if (n !== 33) begin failures++; $display("FAIL stall_busy_len got %0d want 33", n); end
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL stall_level bad_cycles=%0d want 0", stall_bad); end
    checks++; if (hi_bad !== 0) begin failures++; $display("FAIL stall_hi_held bad_cycles=%0d want 0", hi_bad); end
    checks++; if (bif.done !== 1'b1 || bif.stall !== 1'b0) begin failures++; $display("FAIL stall_done done=%b stall=%b want 1 0", bif.done, bif.stall); end
    checks++; if ({bif.hi, bif.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL stall_div_result got %h_%h want ffffffff_fffffffd", bif.hi, bif.lo); end
    step();
    bif.start = 1'b0; bif.rd_req = 1'b0; bif.mthi = 1'b0;
    checks++; if (bif.hi !== 32'h1234 || bif.busy !== 1'b1) begin failures++; $display("FAIL stall_mthi_accept hi=%h busy=%b want 00001234 1", bif.hi, bif.busy); end
    n = 0;
    while (bif.busy === 1'b1 && n < 200) begin n++; step(); end
    checks++; if ({bif.hi, bif.lo} !== {32'd0, 32'd63} || n !== int'(MLAT)) begin failures++; $display("FAIL stall_second_op got %h_%h after %0d want 0_3f after %0d", bif.hi, bif.lo, n, MLAT); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    bif.mthi = 1'b1; bif.mtlo = 1'b1; bif.mt_data = 32'hAAAA_AAAA;
    step();
    bif.mthi = 1'b0; bif.mtlo = 1'b0;
    bif.start = 1'b1; bif.alu_control = 4'b1101; bif.op1 = 32'd1000; bif.op2 = 32'd3;
    step();
    bif.start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    checks++; if (bif.hi !== 32'hAAAA_AAAA || bif.busy !== 1'b1) begin failures++; $display("FAIL rmid_pre hi=%h busy=%b want aaaaaaaa 1", bif.hi, bif.busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin failures++; $display("FAIL rmid_ctrl busy=%b done=%b want 0 0", bif.busy, bif.done); end
    checks++; if ({bif.hi, bif.lo} !== 64'h0) begin failures++; $display("FAIL rmid_hilo got %h_%h want 0_0", bif.hi, bif.lo); end
    for (int i = 0; i < 40; i++) begin
      if (bif.done === 1'b1) dones++;
      step();
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rmid_no_done got %0d want 0", dones); end
  endtask

  task automatic test_invalid();
    bif.mthi = 1'b1; bif.mtlo = 1'b1; bif.mt_data = 32'h7777_1111;
    step();
    bif.mthi = 1'b0; bif.mtlo = 1'b0;
    bif.start = 1'b1; bif.alu_control = 4'b0001; bif.op1 = 32'd6; bif.op2 = 32'd7;
    step(); step();
    bif.start = 1'b0;
    checks++; if (bif.busy !== 1'b0) begin failures++; $display("FAIL invalid_busy got %b want 0", bif.busy); end
    checks++; if ({bif.hi, bif.lo} !== 64'h7777_1111_7777_1111) begin failures++; $display("FAIL invalid_hilo got %h_%h want 77771111_77771111", bif.hi, bif.lo); end
  endtask

  initial begin
    reset = 1'b1;
    bif.start = 1'b0; bif.alu_control = '0; bif.op1 = '0; bif.op2 = '0;
    bif.mthi = 1'b0; bif.mtlo = 1'b0; bif.mt_data = '0; bif.rd_req = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_random_back_to_back();
    test_mt_idle();
    test_stall();
    test_mt_idle();
    test_reset_mid();
    test_invalid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1);
  end
endmodule
